lc3b_exec_unit: RTL and testbench

Multi-cycle operate-instruction sequencer sitting directly upstream of the LC-3b register file. It accepts one instruction word through a valid/ready handshake and drives the file's sr1/sr2 read addresses. It captures the returned operands, computes ADD/AND/XOR/SHF results, and writes the result back through dr/ldreg/in while updating the NZP condition codes. Non-operate opcodes are flagged illegal and cause no writeback.

---
 rtl/lc3b_pkg.sv | 15 +
 rtl/lc3b_alu.sv | 26 ++
 rtl/lc3b_exec_unit.sv | 76 +++++++
 tb/tb_lc3b_exec_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/lc3b_pkg.sv
// lc3b_pkg: shared opcodes, FSM encoding and condition-code constants for the exec unit
package lc3b_pkg;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b1001;
    localparam logic [3:0] OP_SHF = 4'b1101;
    localparam int N_BIT = 2;
    localparam int Z_BIT = 1;
    localparam int P_BIT = 0;
    localparam logic [2:0] NZP_RST = 3'b010;
    typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WB, S_ERR} state_t;
    function automatic logic is_operate(input logic [3:0] op);
        return op == OP_ADD || op == OP_AND || op == OP_XOR || op == OP_SHF;
    endfunction
endpackage

// File: rtl/lc3b_alu.sv
// lc3b_alu: combinational ADD/AND/XOR/SHF datapath for operate instructions
module lc3b_alu
    import lc3b_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        opcode,
    input  logic [5:0]        ir_lo,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] result
);
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] sra;
    logic [DATA_W-1:0] shf;
    // arithmetic shift kept in its own assignment so it stays signed
    always_comb begin
        b = ir_lo[5] ? {{(DATA_W-5){ir_lo[4]}}, ir_lo[4:0]} : op_b;
        sra = $signed(op_a) >>> ir_lo[3:0];
        shf = !ir_lo[4] ? op_a << ir_lo[3:0] : ir_lo[5] ? sra : op_a >> ir_lo[3:0];
        result = opcode == OP_ADD ? op_a + b :
                 opcode == OP_AND ? op_a & b :
                 opcode == OP_XOR ? op_a ^ b :
                 opcode == OP_SHF ? shf : '0;
    end
endmodule

// File: rtl/lc3b_exec_unit.sv
// lc3b_exec_unit: 4-cycle operate-instruction sequencer feeding the LC-3b register file
module lc3b_exec_unit
    import lc3b_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 3
) (
    input  logic               clk_50,
    input  logic               reset,
    input  logic [DATA_W-1:0]  instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [RADDR_W-1:0] sr1,
    output logic [RADDR_W-1:0] sr2,
    input  logic [DATA_W-1:0]  sr1_data,
    input  logic [DATA_W-1:0]  sr2_data,
    output logic [RADDR_W-1:0] dr,
    output logic               ldreg,
    output logic [DATA_W-1:0]  wb_data,
    output logic [2:0]         nzp,
    output logic               done,
    output logic               illegal
);
    state_t state, state_nx;
    logic [DATA_W-1:0] ir, op_a, op_b, result, alu_y;
    logic busy;

    lc3b_alu #(.DATA_W(DATA_W)) u_alu (
        .opcode(ir[15:12]),
        .ir_lo (ir[5:0]),
        .op_a  (op_a),
        .op_b  (op_b),
        .result(alu_y)
    );

    // next-state sequencing and per-state outputs
    always_comb begin
        state_nx = S_IDLE;
        case (state)
            S_IDLE: state_nx = !instr_valid ? S_IDLE : is_operate(instr[15:12]) ? S_READ : S_ERR;
            S_READ: state_nx = S_EXEC;
            S_EXEC: state_nx = S_WB;
            default: state_nx = S_IDLE;
        endcase
        busy = state == S_READ || state == S_EXEC || state == S_WB;
        instr_ready = state == S_IDLE && !reset;
        sr1 = busy ? ir[6 +: RADDR_W] : '0;
        sr2 = busy ? ir[0 +: RADDR_W] : '0;
        ldreg = state == S_WB;
        done = state == S_WB;
        dr = state == S_WB ? ir[9 +: RADDR_W] : '0;
        wb_data = state == S_WB ? result : '0;
        illegal = state == S_ERR;
    end

    // state, instruction/operand/result capture and condition-code update
    always_ff @(posedge clk_50) begin
        if (reset) begin
            state <= S_IDLE;
            ir <= '0;
            op_a <= '0;
            op_b <= '0;
            result <= '0;
            nzp <= NZP_RST;
        end else begin
            state <= state_nx;
            if (instr_ready && instr_valid) ir <= instr;
            if (state == S_READ) begin
                op_a <= sr1_data;
                op_b <= sr2_data;
            end
            if (state == S_EXEC) result <= alu_y;
            if (state == S_WB) nzp <= result[DATA_W-1] ? 3'(1 << N_BIT) : result == '0 ? 3'(1 << Z_BIT) : 3'(1 << P_BIT);
        end
    end
endmodule

// File: tb/tb_lc3b_exec_unit.sv
// tb_lc3b_exec_unit: scoreboard bench with a register-file model around the exec unit
module tb_lc3b_exec_unit;
    logic        clk_50 = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [2:0]  sr1, sr2, dr;
    logic [15:0] sr1_data, sr2_data, wb_data;
    logic        ldreg, done, illegal;
    logic [2:0]  nzp;
    logic        rf_clr = 1'b1;
    logic [15:0] rf [8];

    typedef struct {
        logic [15:0] data;
        logic [2:0]  dr;
        logic [2:0]  nzp;
        bit          ill;
        int          at;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hs_count = 0;
    int ld_count = 0;

    lc3b_exec_unit #(.DATA_W(16), .RADDR_W(3)) dut (
        .clk_50(clk_50), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .sr1(sr1), .sr2(sr2), .sr1_data(sr1_data),
        .sr2_data(sr2_data), .dr(dr), .ldreg(ldreg), .wb_data(wb_data),
        .nzp(nzp), .done(done), .illegal(illegal)
    );

    always #5 clk_50 = ~clk_50;

    assign sr1_data = rf[sr1];
    assign sr2_data = rf[sr2];

    always_ff @(posedge clk_50) begin
        if (rf_clr) for (int i = 0; i < 8; i++) rf[i] <= '0;
        else if (ldreg) rf[dr] <= wb_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk_50);
        cyc++;
    end

    // monitor: counts handshakes, pops the scoreboard on every output event
    initial begin
        exp_t e;
        bit nzp_pend = 0;
        bit rdy_pend = 0;
        logic [2:0] pend_nzp = '0;
        forever begin
            @(negedge clk_50);
            if (instr_valid && instr_ready) hs_count++;
            if (nzp_pend) begin
                chk("nzp_after_wb", 32'(nzp), 32'(pend_nzp));
                nzp_pend = 0;
            end
            if (rdy_pend) begin
                chk("ready_after_illegal", 32'(instr_ready), 1);
                rdy_pend = 0;
            end
            if (ldreg) ld_count++;
            if (ldreg || done || illegal) begin
                if (q.size() == 0) chk("unexpected_output", {29'd0, ldreg, done, illegal}, 0);
                else begin
                    e = q.pop_front();
                    chk("latency", 32'(cyc), 32'(e.at));
                    chk("illegal", 32'(illegal), 32'(e.ill));
                    chk("ldreg", 32'(ldreg), 32'(!e.ill));
                    chk("done", 32'(done), 32'(!e.ill));
                    if (e.ill) begin
                        chk("nzp_held", 32'(nzp), 32'(e.nzp));
                        rdy_pend = 1;
                    end else begin
                        chk("dr", 32'(dr), 32'(e.dr));
                        chk("wb_data", 32'(wb_data), 32'(e.data));
                        pend_nzp = e.nzp;
                        nzp_pend = 1;
                    end
                end
            end
        end
    end

    // present one instruction, wait for acceptance, then hold valid for extra busy cycles
    task automatic issue(input logic [15:0] w, input logic [2:0] d, input logic [15:0] data,
                         input logic [2:0] flags, input bit ill, input bit push, input int hold);
        int t = 0;
        exp_t e;
        @(posedge clk_50);
        #1 instr = w;
        instr_valid = 1'b1;
        @(negedge clk_50);
        while (!instr_ready && t < 50) begin
            @(negedge clk_50);
            t++;
        end
        if (t >= 50) chk("ready_timeout", 0, 1);
        e.data = data;
        e.dr = d;
        e.nzp = flags;
        e.ill = ill;
        e.at = cyc + 1 + (ill ? 0 : 2);
        if (push) q.push_back(e);
        @(posedge clk_50);
        repeat (hold) @(posedge clk_50);
        #1 instr_valid = 1'b0;
    endtask

    initial begin
        int t;
        repeat (2) @(posedge clk_50);
        @(negedge clk_50);
        chk("rst_ready", 32'(instr_ready), 0);
        chk("rst_sr1", 32'(sr1), 0);
        chk("rst_sr2", 32'(sr2), 0);
        chk("rst_dr", 32'(dr), 0);
        chk("rst_ldreg", 32'(ldreg), 0);
        chk("rst_wb_data", 32'(wb_data), 0);
        chk("rst_nzp", 32'(nzp), 32'h2);
        chk("rst_done", 32'(done), 0);
        chk("rst_illegal", 32'(illegal), 0);
        @(posedge clk_50);
        #1 reset = 1'b0;
        rf_clr = 1'b0;
        @(negedge clk_50);
        chk("ready_after_rst", 32'(instr_ready), 1);

        issue(16'h1225, 3'd1, 16'h0005, 3'b001, 0, 1, 0);
        issue(16'h1441, 3'd2, 16'h000A, 3'b001, 0, 1, 2);
        issue(16'h96BF, 3'd3, 16'hFFF5, 3'b100, 0, 1, 0);
        issue(16'h0000, 3'd0, 16'h0000, 3'b100, 1, 1, 0);
        issue(16'hD8F2, 3'd4, 16'hFFFD, 3'b100, 0, 1, 0);
        issue(16'hD8D4, 3'd4, 16'h0FFF, 3'b001, 0, 1, 0);
        issue(16'h56E3, 3'd3, 16'h0001, 3'b001, 0, 1, 0);

        issue(16'h1225, 3'd1, 16'h0005, 3'b001, 0, 0, 0);
        @(posedge clk_50);
        #1 reset = 1'b1;
        @(negedge clk_50);
        chk("ready_in_reset", 32'(instr_ready), 0);
        @(posedge clk_50);
        #1 reset = 1'b0;
        @(negedge clk_50);
        chk("ready_post_reset", 32'(instr_ready), 1);
        chk("nzp_post_reset", 32'(nzp), 32'h2);
        chk("ldreg_post_reset", 32'(ldreg), 0);

        issue(16'hDA8F, 3'd5, 16'h0000, 3'b010, 0, 1, 0);

        t = 0;
        while (q.size() != 0 && t < 40) begin
            @(negedge clk_50);
            t++;
        end
        chk("drain", 32'(q.size()), 0);
        repeat (6) @(negedge clk_50);
        chk("handshakes", 32'(hs_count), 9);
        chk("writebacks", 32'(ld_count), 7);
        chk("rf_r1", 32'(rf[1]), 32'h0005);
        chk("rf_r2", 32'(rf[2]), 32'h000A);
        chk("rf_r3", 32'(rf[3]), 32'h0001);
        chk("rf_r4", 32'(rf[4]), 32'h0FFF);
        chk("rf_r5", 32'(rf[5]), 32'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
